bram_read_port: RTL
===================

# bram_read_port

Request/response front-end for the team's simple dual-port block RAM (one registered read port, one write port, 1-cycle read latency, read-first on same-address collision). Accepts read requests over a valid/ready handshake, drives the RAM read port, and returns read data in order through a 3-entry response FIFO, so the requester sees full-throughput backpressure handling without a combinational path from `resp_ready` to `req_ready`. It also forwards the write port to the RAM and snoops it so that a read issued in the same cycle as a same-address write returns the new data.

## Interface
- `ADDR_WIDTH`, default 8: RAM address width.
- `DATA_WIDTH`, default 32: RAM data width.
- `FIFO_DEPTH`, fixed 3: response FIFO entries. Not overridable.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  read request valid.
- `req_ready`  out  1  request accepted when `req_valid & req_ready`.
- `req_addr`  in  ADDR_WIDTH  read address.
- `resp_valid`  out  1  head of the response FIFO is valid.
- `resp_ready`  in  1  consumer accepts the head entry.
- `resp_data`  out  DATA_WIDTH  head-entry data.
- `wr_en`  in  1  write request; always accepted.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `ram_en`  out  1  to RAM read enable.
- `ram_addr`  out  ADDR_WIDTH  to RAM read address.
- `ram_rdata`  in  DATA_WIDTH  from RAM registered read data.
- `ram_we`, `ram_waddr`, `ram_wdata`  out  1/ADDR_WIDTH/DATA_WIDTH  to RAM write port.

## Operation
- State: `inflight` (1 bit, a read was issued last cycle); `byp_hit`, `byp_data` (collision capture); FIFO with `count` (0..3), read pointer, and write pointer (mod 3).
- `req_ready` = `rstn & (count + inflight < 3)`. It depends only on registered state and `rstn`.
- Issue: `fire = req_valid & req_ready`. `ram_en = fire`, `ram_addr = req_addr` (combinational). Next `inflight = fire`.
- Collision: `hit = fire & wr_en & (wr_addr == req_addr)`. On `fire`, register `byp_hit <= hit` and `byp_data <= wr_data`.
- Capture: when `inflight` is 1, push `byp_hit ? byp_data : ram_rdata` into the FIFO at the write pointer.
- The write port is pure pass-through: `ram_we = wr_en`, `ram_waddr = wr_addr`, `ram_wdata = wr_data`.
- Pop: `resp_valid = (count != 0)`. `resp_data` is the FIFO head. On `resp_valid & resp_ready`, advance the read pointer.
- Simultaneous push and pop leave `count` unchanged. Both pointers wrap 2→0.
- Ordering: responses leave in request order, exactly one per accepted request.
- Overflow is impossible by construction. A push when `count == 3` is an assertion failure.
- Reset (asynchronous, any time): clears `count`, pointers, `inflight` and `byp_hit`.
  - Requests in flight at reset are discarded, and their RAM data is never pushed.
  - FIFO storage is not reset.
  - `ram_en` is 0 while reset is asserted, because `req_ready` is 0.

## Timing
- Reset values: `req_ready` 0 (1 after release), `resp_valid` 0, `ram_en` 0, `resp_data` don't-care.
- Latency: a request accepted at edge N has its RAM data at edge N+1, is pushed at edge N+1, and shows `resp_valid` in cycle N+1→N+2. That is 2 cycles from accept to `resp_valid`.
- Throughput: 1 request/cycle sustained while `resp_ready` = 1.
- Backpressure: with `resp_ready` = 0, at most 3 requests are accepted. `req_ready` falls in the cycle after the 3rd accept.
- `req_ready` recovers the cycle after a pop frees a slot.
- `resp_valid`/`resp_data` hold stable while `resp_ready` = 0.

## Test plan
- Reset release, then write mem[5]=0xA5A5_0001, then request addr 5 with `resp_ready`=1 → `resp_valid` 2 cycles after accept with data 0xA5A5_0001. No other responses.
- Back-to-back requests to addresses 0..15 with `resp_ready`=1 → `req_ready` never drops, and 16 responses arrive in order at 1/cycle.
- `resp_ready`=0 with `req_valid` held high → exactly 3 accepts, then `req_ready`=0 and `count`=3. Raise `resp_ready` → 3 in-order responses, and `req_ready` returns the cycle after the first pop.
- Same-cycle write 0x1234 to addr 7 (old value 0xFFFF) and read addr 7 → response is 0x1234. A read of addr 7 issued in the next cycle also returns 0x1234.
- Assert `rstn`=0 with one request in flight and 2 entries buffered, then release → `resp_valid`=0, no stale response ever appears, and the next request returns correct data.
- Random `req_valid`/`resp_ready`/`wr_en` traffic for 10k cycles against a scoreboard memory model → all responses match, in order, and the FIFO never overflows.

Source files
------------

// File: rtl/bram_read_port_if.sv
// Request/response handshake bundle for the block-RAM read front-end.
// The requester drives master; bram_read_port takes slave.
interface bram_read_port_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/bram_read_port.sv
// In-order read front-end for a 1-cycle-latency simple dual-port RAM.
// Responses are buffered in a 3-entry FIFO; same-cycle writes are bypassed.
module bram_read_port #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    bram_read_port_if.slave       rp,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata
);
    localparam int FIFO_DEPTH = 3;

    logic [1:0]            count_reg, count_next;
    logic [1:0]            rd_ptr_reg, rd_ptr_next;
    logic [1:0]            wr_ptr_reg, wr_ptr_next;
    logic                  inflight_reg;
    logic                  byp_hit_reg;
    logic [DATA_WIDTH-1:0] byp_data_reg;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                  fire;
    logic                  hit;
    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic [DATA_WIDTH-1:0] push_data;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserving a slot for the in-flight read keeps resp_ready off the req_ready path.
    assign occupancy    = {1'b0, count_reg} + {2'b00, inflight_reg};
    assign rp.req_ready = rstn & (occupancy < 3'(FIFO_DEPTH));
    assign fire         = rp.req_valid & rp.req_ready;

    assign ram_en    = fire;
    assign ram_addr  = rp.req_addr;
    assign ram_we    = wr_en;
    assign ram_waddr = wr_addr;
    assign ram_wdata = wr_data;

    // The RAM is read-first, so a colliding write must be substituted here.
    assign hit       = fire & wr_en & (wr_addr == rp.req_addr);
    assign push      = inflight_reg;
    assign push_data = byp_hit_reg ? byp_data_reg : ram_rdata;

    assign rp.resp_valid = (count_reg != 2'd0);
    assign rp.resp_data  = fifo_mem[rd_ptr_reg];
    assign pop           = rp.resp_valid & rp.resp_ready;

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (push) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (pop) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            wr_ptr_reg   <= 2'd0;
            inflight_reg <= 1'b0;
            byp_hit_reg  <= 1'b0;
        end else begin
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            inflight_reg <= fire;
            if (fire) begin
                byp_hit_reg <= hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            byp_data_reg <= wr_data;
        end
    end

    // Storage is intentionally not reset; count_reg gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && count_reg == 2'd3));

endmodule
